// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES core driver and core wrappers
package aes_pkg;
  typedef enum logic [1:0] {NOKEY, KEY_WAIT, IDLE, BLK_WAIT} aes_state_e;
  typedef logic [127:0] aes_block_t;
  localparam int AES_GUARD = 2;
endpackage

// File: rtl/aes_out_buf.sv
// aes_out_buf: one-entry valid/ready result holding register with capture and drain
module aes_out_buf import aes_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cap,
  input  aes_block_t i_data,
  input  logic       i_ready,
  output aes_block_t o_data,
  output logic       o_valid
);
  always_ff @(posedge clk)
    if (rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_cap) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
    end else if (o_valid && i_ready)
      o_valid <= 1'b0;
endmodule

// File: rtl/aes_core_driver.sv
// aes_core_driver: sequences key/block handshakes to an AES core with guard, timeout and result buffer
module aes_core_driver import aes_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = 32
) (
  input  logic             aclk,
  input  logic             reset,
  input  aes_block_t       s_key,
  input  logic             s_key_valid,
  output logic             s_key_ready,
  input  aes_block_t       s_blk,
  input  logic             s_blk_valid,
  output logic             s_blk_ready,
  output aes_block_t       m_blk,
  output logic             m_blk_valid,
  input  logic             m_blk_ready,
  output aes_block_t       core_key,
  output logic             core_key_init,
  input  logic             core_key_ready,
  output aes_block_t       core_input_block,
  output logic             core_next,
  input  aes_block_t       core_output_block,
  input  logic             core_block_ready,
  output logic             key_loaded,
  output logic             busy,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] blk_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  aes_state_e r_state;
  logic [TW-1:0] r_wait;
  logic w_wait, w_rdy, w_done, w_tout, w_key_hs, w_blk_hs, w_cap;
  assign w_wait      = r_state == KEY_WAIT || r_state == BLK_WAIT;
  assign busy        = w_wait;
  assign s_key_ready = r_state == NOKEY || r_state == IDLE;
  assign s_blk_ready = r_state == IDLE && !s_key_valid && (!m_blk_valid || m_blk_ready);
  assign w_key_hs    = s_key_valid && s_key_ready;
  assign w_blk_hs    = s_blk_valid && s_blk_ready;
  assign w_rdy       = r_state == KEY_WAIT ? core_key_ready : core_block_ready;
  assign w_done      = w_wait && r_wait >= TW'(AES_GUARD) && w_rdy;
  assign w_tout      = w_wait && !w_done && r_wait == TW'(TIMEOUT_CYCLES - 1);
  assign w_cap       = w_done && r_state == BLK_WAIT;
  always_ff @(posedge aclk)
    if (reset) begin
      r_state          <= NOKEY;
      r_wait           <= '0;
      core_key         <= '0;
      core_key_init    <= 1'b0;
      core_input_block <= '0;
      core_next        <= 1'b0;
      key_loaded       <= 1'b0;
      err              <= 1'b0;
      blk_count        <= '0;
    end else begin
      core_key_init <= 1'b0;
      core_next     <= 1'b0;
      r_wait        <= w_wait ? r_wait + 1'b1 : '0;
      err           <= w_tout || (err && !err_clr);
      if (w_key_hs) begin
        core_key      <= s_key;
        core_key_init <= 1'b1;
        key_loaded    <= 1'b0;
        blk_count     <= '0;
        r_state       <= KEY_WAIT;
      end else if (w_blk_hs) begin
        core_input_block <= s_blk;
        core_next        <= 1'b1;
        r_state          <= BLK_WAIT;
      end else if (w_done) begin
        r_state <= IDLE;
        if (r_state == KEY_WAIT) key_loaded <= 1'b1;
        else blk_count <= blk_count + 1'b1;
      end else if (w_tout) begin
        r_state    <= NOKEY;
        key_loaded <= 1'b0;
      end
    end
  aes_out_buf u_buf (
    .clk     (aclk),
    .rst     (reset),
    .i_cap   (w_cap),
    .i_data  (core_output_block),
    .i_ready (m_blk_ready),
    .o_data  (m_blk),
    .o_valid (m_blk_valid)
  );
endmodule

// File: tb/tb_aes_core_driver.sv
// tb_aes_core_driver: directed table-driven bench with a behavioural AES core stand-in
module tb_aes_core_driver;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 0, reset = 1;
  logic [127:0] s_key = '0, s_blk = '0, m_blk, core_key, core_input_block, core_output_block = '0;
  logic s_key_valid = 0, s_key_ready, s_blk_valid = 0, s_blk_ready, m_blk_valid, m_blk_ready = 0;
  logic core_key_init, core_key_ready = 0, core_next, core_block_ready = 0;
  logic key_loaded, busy, err, err_clr = 0;
  logic [31:0] blk_count;
  int n_run = 0, n_fail = 0;
  bit stale_key = 0, blk_never = 0;
  int key_lat = 1, blk_lat = 1, kc = 0, bc = 0;
  typedef struct {
    logic [127:0] key;
    logic [127:0] blk;
    logic [127:0] exp;
    logic         new_key;
    int           lat;
    logic [31:0]  cnt;
  } vec_t;
  vec_t vt[4];

  aes_core_driver #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
    .aclk(clk), .reset(reset),
    .s_key(s_key), .s_key_valid(s_key_valid), .s_key_ready(s_key_ready),
    .s_blk(s_blk), .s_blk_valid(s_blk_valid), .s_blk_ready(s_blk_ready),
    .m_blk(m_blk), .m_blk_valid(m_blk_valid), .m_blk_ready(m_blk_ready),
    .core_key(core_key), .core_key_init(core_key_init), .core_key_ready(core_key_ready),
    .core_input_block(core_input_block), .core_next(core_next),
    .core_output_block(core_output_block), .core_block_ready(core_block_ready),
    .key_loaded(key_loaded), .busy(busy), .err(err), .err_clr(err_clr), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic [127:0] b, input logic [127:0] k);
    return (b == FP && k == FK) ? FC : b ^ k;
  endfunction

  always @(negedge clk) begin
    if (core_key_init) begin
      core_key_ready = stale_key;
      kc = key_lat;
    end else if (kc > 0) begin
      kc--;
      if (kc == 0) core_key_ready = 1;
    end
    if (core_next) begin
      core_block_ready = 0;
      bc = blk_never ? 0 : blk_lat;
    end else if (bc > 0) begin
      bc--;
      if (bc == 0) begin
        core_block_ready = 1;
        core_output_block = core_fn(core_input_block, core_key);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_run++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic wait_sig(input string nm, input bit sel);
    int i = 0;
    while (!(sel ? m_blk_valid : key_loaded) && i < 100) begin
      tick;
      i++;
    end
    if (i == 100) bound_fail(nm);
  endtask

  task automatic send_key(input logic [127:0] k);
    int i = 0;
    s_key = k;
    s_key_valid = 1;
    #1;
    while (!s_key_ready && i < 100) begin
      tick;
      i++;
    end
    if (i == 100) bound_fail("key_hs");
    tick;
    s_key_valid = 0;
    chk("key_init_on", core_key_init, 1);
    chk("core_key", core_key, k);
    chk("key_busy", busy, 1);
    tick;
    chk("key_init_off", core_key_init, 0);
  endtask

  task automatic send_blk(input logic [127:0] b);
    int i = 0;
    s_blk = b;
    s_blk_valid = 1;
    #1;
    while (!s_blk_ready && i < 100) begin
      tick;
      i++;
    end
    if (i == 100) bound_fail("blk_hs");
    tick;
    s_blk_valid = 0;
    chk("core_next_on", core_next, 1);
    chk("core_input_block", core_input_block, b);
  endtask

  task automatic recv(input logic [127:0] exp, input logic [31:0] cnt);
    wait_sig("m_blk_valid", 1);
    chk("m_blk", m_blk, exp);
    chk("blk_count", blk_count, cnt);
    chk("core_next_off", core_next, 0);
    m_blk_ready = 1;
    tick;
    m_blk_ready = 0;
    chk("drained", m_blk_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bk, bb[4];
    int si, ri, cyc;
    bit seen, ihs, ohs, late;
    vt[0] = '{FK, FP, FC, 1'b1, 1, 32'd1};
    vt[1] = '{FK, 128'h0, FK, 1'b0, 3, 32'd2};
    vt[2] = '{{4{32'hffffffff}}, 128'h0123456789abcdef_fedcba9876543210,
              128'hfedcba9876543210_0123456789abcdef, 1'b1, 1, 32'd1};
    vt[3] = '{{4{32'hffffffff}}, {4{32'hffffffff}}, 128'h0, 1'b0, 5, 32'd2};
    repeat (3) tick;
    chk("rst_m_blk_valid", m_blk_valid, 0);
    chk("rst_m_blk", m_blk, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_flags", {key_loaded, busy, err, core_key_init, core_next}, 0);
    chk("rst_blk_count", blk_count, 0);
    reset = 0;
    tick;
    chk("nokey_key_ready", s_key_ready, 1);
    chk("nokey_blk_ready", s_blk_ready, 0);

    for (int v = 0; v < 4; v++) begin
      if (vt[v].new_key) begin
        send_key(vt[v].key);
        wait_sig("key_loaded", 0);
        chk("key_loaded", key_loaded, 1);
        chk("cnt_after_key", blk_count, 0);
      end
      blk_lat = vt[v].lat;
      send_blk(vt[v].blk);
      recv(vt[v].exp, vt[v].cnt);
      chk("key_stable", core_key, vt[v].key);
    end

    bk = {4{32'h0f1e2d3c}};
    bb[0] = 128'h11; bb[1] = 128'h22; bb[2] = 128'h33; bb[3] = 128'h44;
    blk_lat = 1;
    send_key(bk);
    wait_sig("key_loaded_b2b", 0);
    si = 0; ri = 0; seen = 0;
    for (cyc = 0; cyc < 200 && ri < 4; cyc++) begin
      s_blk = bb[si & 3];
      s_blk_valid = si < 4;
      m_blk_ready = seen && cyc[0];
      #1;
      if (m_blk_valid && !m_blk_ready) chk("full_stall", s_blk_ready, 0);
      ohs = m_blk_valid && m_blk_ready;
      ihs = s_blk_valid && s_blk_ready;
      if (ohs) begin
        chk("b2b_m_blk", m_blk, bb[ri] ^ bk);
        chk("b2b_count", blk_count, ri + 1);
      end
      if (m_blk_valid) seen = 1;
      tick;
      si += int'(ihs);
      ri += int'(ohs);
    end
    s_blk_valid = 0;
    m_blk_ready = 0;
    if (ri < 4) bound_fail("b2b_results");
    chk("b2b_final_count", blk_count, 4);

    blk_never = 1;
    send_blk(128'h5);
    chk("to_busy", busy, 1);
    chk("to_err0", err, 0);
    repeat (15) tick;
    chk("to_err_early", err, 0);
    chk("to_busy_late", busy, 1);
    tick;
    chk("to_err", err, 1);
    chk("to_key_loaded", key_loaded, 0);
    chk("to_nokey", {busy, s_key_ready}, 2'b01);
    blk_never = 0;
    tick;
    chk("to_err_sticky", err, 1);
    err_clr = 1;
    tick;
    err_clr = 0;
    chk("to_err_clr", err, 0);

    stale_key = 1;
    core_key_ready = 1;
    send_key(FK);
    chk("stale_c1_busy", busy, 1);
    tick;
    chk("stale_c2_busy", busy, 1);
    chk("stale_c2_loaded", key_loaded, 0);
    tick;
    chk("stale_c3_busy", busy, 0);
    chk("stale_c3_loaded", key_loaded, 1);
    stale_key = 0;

    bk = 128'hdeadbeef_00000000_cafef00d_12345678;
    s_key = bk;
    s_blk = 128'h77;
    s_key_valid = 1;
    s_blk_valid = 1;
    #1;
    chk("both_key_ready", s_key_ready, 1);
    chk("both_blk_ready", s_blk_ready, 0);
    tick;
    s_key_valid = 0;
    chk("both_pulses", {core_key_init, core_next}, 2'b10);
    chk("both_core_key", core_key, bk);
    send_blk(128'h77);
    recv(128'h77 ^ bk, 32'd1);

    blk_lat = 5;
    send_blk(128'h99);
    tick;
    reset = 1;
    tick;
    reset = 0;
    chk("mid_rst_m_blk", {m_blk_valid, m_blk}, 0);
    chk("mid_rst_core", {core_key, core_input_block}, 0);
    chk("mid_rst_flags", {key_loaded, busy, err, core_key_init, core_next, s_blk_ready}, 0);
    chk("mid_rst_count", blk_count, 0);
    late = 0;
    repeat (8) begin
      tick;
      late |= m_blk_valid;
    end
    chk("late_core_ready_dropped", late, 0);
    chk("late_still_nokey", {busy, key_loaded, s_key_ready}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
